// File: rtl/cpu_pkg.sv
// Shared constants and types for the 16-bit CPU front end.
// The FETCH_HALT_EN build option uses HALT_WORD as the stop marker.
package cpu_pkg;

  localparam int IW = 16;
  localparam int AW = 5;
  localparam logic [AW-1:0] RESET_PC  = '0;
  localparam logic [IW-1:0] HALT_WORD = 16'h0000;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } fetch_entry_t;

  // Sequential successor of a PC; wraps modulo 2^AW.
  function automatic logic [AW-1:0] pc_next(input logic [AW-1:0] pc);
    return pc + {{(AW-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory read port, redirect input and the
// decode handshake. Decode handshake: instr/instr_pc are meaningful only
// while instr_valid=1; a word transfers on an edge where instr_valid and
// instr_ready are both 1; while instr_valid=1 and instr_ready=0 the word
// is held unchanged.
interface instr_fetch_if;
  import cpu_pkg::*;

  logic          im_rd_en;
  logic [AW-1:0] im_addr;
  logic [IW-1:0] im_rdata;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;
  logic          halted;

  modport master (
    output im_rd_en, im_addr, instr_valid, instr, instr_pc, halted,
    input  im_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  im_rd_en, im_addr, instr_valid, instr, instr_pc, halted,
    output im_rdata, redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, instr} between the instruction memory and decode.
// Flush empties the queue; a push and a pop in the same cycle both happen.
module fetch_queue
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   occ,
  output logic         full,
  output logic         empty
);

  fetch_entry_t slots [2];
  logic         rd_ptr;
  logic         wr_ptr;

  assign head  = slots[rd_ptr];
  assign full  = (occ == 2'd2);
  assign empty = (occ == 2'd0);

  // Storage, pointers and occupancy; reset also clears the stored words so
  // the head reads as zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slots[0] <= '0;
      slots[1] <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      occ      <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        slots[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues sequential reads to a 1-cycle-latency
// instruction memory, buffers returns in a 2-entry queue and presents them
// to decode. Redirects flush the queue and kill the returning word.
// Build option FETCH_HALT_EN: a returned HALT_WORD is delivered, then
// fetch stops (halted=1) until reset or redirect.
module instr_fetch
  import cpu_pkg::*;
(
  input  logic              CLK,
  input  logic              START,
  instr_fetch_if.master     bus
);

  logic          run;        // set on the first edge with START=1
  logic [AW-1:0] pc;
  logic          inflight;   // a read was issued last cycle
  logic [AW-1:0] req_pc;     // address of the read in flight
  logic          halted_q;

  logic          pop;
  logic          push;
  logic          kill;
  logic          issue;
  logic [2:0]    credit_sum;
  logic [1:0]    occ;
  logic          full;
  logic          empty;
  fetch_entry_t  head;
  fetch_entry_t  push_data;

  assign pop = bus.instr_valid & bus.instr_ready;

  // Credit rule: queued + in-flight words, less the one leaving this cycle,
  // must stay below the queue depth for a new read to be safe.
  assign credit_sum = {1'b0, occ} + {2'b0, inflight};
  assign issue = START & run & ~bus.redirect_valid & ~halted_q &
                 (credit_sum < (3'd2 + {2'b0, pop}));

  // The returning word is discarded when a redirect lands on the same edge
  // or fetch is already halted.
  assign kill      = bus.redirect_valid | halted_q;
  assign push      = inflight & ~kill;
  assign push_data = '{pc: req_pc, instr: bus.im_rdata};

  assign bus.im_rd_en    = issue;
  assign bus.im_addr     = pc;
  assign bus.instr_valid = ~empty;
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;
  assign bus.halted      = halted_q;

  fetch_queue u_queue (
    .clk       (CLK),
    .rst_n     (START),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .head      (head),
    .occ       (occ),
    .full      (full),
    .empty     (empty)
  );

  // PC, run flag and in-flight tracking.
  always_ff @(posedge CLK) begin
    if (!START) begin
      run      <= 1'b0;
      pc       <= RESET_PC;
      inflight <= 1'b0;
      req_pc   <= '0;
    end else begin
      run      <= 1'b1;
      inflight <= issue;
      if (issue) begin
        req_pc <= pc;
      end
      if (bus.redirect_valid) begin
        pc <= bus.redirect_pc;
      end else if (issue) begin
        pc <= pc_next(pc);
      end
    end
  end

`ifdef FETCH_HALT_EN
  // Halt latch: set when a HALT_WORD is accepted into the queue.
  always_ff @(posedge CLK) begin
    if (!START) begin
      halted_q <= 1'b0;
    end else if (bus.redirect_valid) begin
      halted_q <= 1'b0;
    end else if (push && (bus.im_rdata == HALT_WORD)) begin
      halted_q <= 1'b1;
    end
  end
`else
  assign halted_q = 1'b0;
`endif

  // The credit rule must never let a push land on a full queue.
  a_no_overflow: assert property (@(posedge CLK) disable iff (!START)
                                  !(push && full && !pop));

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic.
// The reference model is the architectural instruction stream: after a
// reset or redirect to T, decode must receive IM[T], IM[T+1], ... (mod 32),
// each exactly once and in order; under FETCH_HALT_EN the stream ends after
// the first zero word.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic start = 1'b0;

  instr_fetch_if bus ();

  instr_fetch dut (
    .CLK   (clk),
    .START (start),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [IW-1:0]    mem [32];
  logic [AW+IW-1:0] exp_q [$];
  logic [AW-1:0]    next_pc;
  bit               stream_halted;
  int               checks = 0;
  int               errors = 0;
  int               accepts = 0;

  // Instruction memory: synchronous read, data valid the next cycle.
  always @(posedge clk) begin
    if (bus.im_rd_en === 1'b1) bus.im_rdata <= mem[bus.im_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic restart(input logic [AW-1:0] target);
    exp_q.delete();
    next_pc       = target;
    stream_halted = 1'b0;
  endtask

  task automatic topup();
    while (exp_q.size() < 4 && !stream_halted) begin
      exp_q.push_back({next_pc, mem[next_pc]});
`ifdef FETCH_HALT_EN
      if (mem[next_pc] == 16'h0000) stream_halted = 1'b1;
`endif
      next_pc = next_pc + 5'd1;
    end
  endtask

  // One clock cycle: commit the model for the edge just taken, then drive
  // the next cycle's inputs and return at the falling edge.
  task automatic step(input logic s, input logic rv, input logic [AW-1:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    if (!start) restart(RESET_PC);
    else if (bus.redirect_valid) restart(bus.redirect_pc);
    topup();
    #1;
    start              = s;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.instr_ready    = rdy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  // Steps at least once, then until instr_valid or the budget runs out.
  task automatic wait_valid(input logic rdy, output int n);
    n = 0;
    do begin
      step(1'b1, 1'b0, '0, rdy);
      n++;
    end while (!bus.instr_valid && n < 12);
    check("wait_valid_timeout", bus.instr_valid, 1);
  endtask

  // Monitor: every completed handshake must be the next word of the stream.
  always @(negedge clk) begin
    logic [AW+IW-1:0] e;
    if (start && bus.instr_valid && bus.instr_ready) begin
      accepts++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deliver: got pc %0d instr %h, expected no delivery", bus.instr_pc, bus.instr);
      end else begin
        e = exp_q.pop_front();
        check("deliver", {bus.instr_pc, bus.instr}, e);
      end
    end
  end

  initial begin
    int n;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom_range(1, 16'hFFFF));
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;

    // Reset state and first-fetch latency, back-to-back delivery.
    do_reset();
    check("rst_instr_valid", bus.instr_valid, 0);
    check("rst_im_rd_en", bus.im_rd_en, 0);
    check("rst_halted", bus.halted, 0);
    check("rst_instr", bus.instr, 0);
    check("rst_instr_pc", bus.instr_pc, 0);
    step(1'b1, 1'b0, '0, 1'b1);
    check("rd_en_before_first_edge", bus.im_rd_en, 0);
    step(1'b1, 1'b0, '0, 1'b1);
    check("first_rd_en", bus.im_rd_en, 1);
    check("first_addr", bus.im_addr, 0);
    wait_valid(1'b1, n);
    check("first_valid_latency", n, 2);
    check("first_pc", bus.instr_pc, 0);
    for (int i = 1; i < 4; i++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      check("b2b_valid", bus.instr_valid, 1);
      check("b2b_pc", bus.instr_pc, i);
    end

    // Decode stall: head held, issue stops, no gap on release.
    do_reset();
    step(1'b1, 1'b0, '0, 1'b0);
    wait_valid(1'b0, n);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, '0, 1'b0);
      check("stall_instr", bus.instr, 16'h1111);
      check("stall_pc", bus.instr_pc, 0);
      check("stall_rd_en", bus.im_rd_en, 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      check("release_valid", bus.instr_valid, 1);
      check("release_pc", bus.instr_pc, i);
    end

    // Redirect with pc 2 queued and pc 3 in flight.
    do_reset();
    step(1'b1, 1'b0, '0, 1'b0);
    wait_valid(1'b0, n);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 5'd10, 1'b0);
    check("pre_redirect_head", bus.instr_pc, 2);
    check("redirect_cycle_rd_en", bus.im_rd_en, 0);
    step(1'b1, 1'b0, '0, 1'b1);
    check("post_redirect_rd_en", bus.im_rd_en, 1);
    check("post_redirect_addr", bus.im_addr, 10);
    check("post_redirect_flushed", bus.instr_valid, 0);
    wait_valid(1'b1, n);
    check("redirect_target_pc", bus.instr_pc, 10);
    check("redirect_target_instr", bus.instr, mem[10]);

    // Redirect on the same edge as the pop of pc 1.
    do_reset();
    step(1'b1, 1'b0, '0, 1'b1);
    wait_valid(1'b1, n);
    step(1'b1, 1'b1, 5'd20, 1'b1);
    check("pop_redirect_head", bus.instr_pc, 1);
    wait_valid(1'b1, n);
    check("pop_redirect_target", bus.instr_pc, 20);

    // Redirect near the top of memory: PC wraps.
    step(1'b1, 1'b1, 5'd30, 1'b1);
    wait_valid(1'b1, n);
    check("wrap_pc0", bus.instr_pc, 30);
    step(1'b1, 1'b0, '0, 1'b1);
    check("wrap_pc1", bus.instr_pc, 31);
    step(1'b1, 1'b0, '0, 1'b1);
    check("wrap_pc2", bus.instr_pc, 0);
    step(1'b1, 1'b0, '0, 1'b1);
    check("wrap_pc3", bus.instr_pc, 1);

`ifdef FETCH_HALT_EN
    // Halt on a zero word, then restart through reset.
    mem[2] = 16'h0000;
    do_reset();
    step(1'b1, 1'b0, '0, 1'b1);
    wait_valid(1'b1, n);
    check("halt_pc0", bus.instr_pc, 0);
    step(1'b1, 1'b0, '0, 1'b1);
    check("halt_pc1", bus.instr_pc, 1);
    step(1'b1, 1'b0, '0, 1'b1);
    check("halt_pc2", bus.instr_pc, 2);
    check("halt_word", bus.instr, 16'h0000);
    check("halted_set", bus.halted, 1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      check("halted_no_rd_en", bus.im_rd_en, 0);
      check("halted_hold", bus.halted, 1);
      check("halted_empty", bus.instr_valid, 0);
    end
    mem[2] = 16'h3333;
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    check("halt_cleared", bus.halted, 0);
    wait_valid(1'b1, n);
    check("halt_restart_pc", bus.instr_pc, 0);
`else
    mem[7] = 16'h0000;
`endif

    // Randomized traffic: resets, redirects and decode back-pressure.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 11) == 0),
           5'($urandom_range(0, 31)),
           ($urandom_range(0, 3) != 0));
`ifndef FETCH_HALT_EN
      check("halted_tied_low", bus.halted, 0);
`endif
    end
    check("random_progress", (accepts > 150), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
